// File: rtl/cordic_vec_pipe.sv
// cordic_vec_pipe
// Pipelined CORDIC vectoring engine for the Canny gradient stage. Converts a
// signed Sobel gradient (gx, gy) into a gain-compensated magnitude, a
// full-circle angle in [0,360) degrees and the 4-way direction sector used by
// non-maximum suppression.
//
// Pipeline: one pre-rotation register (stage P), ITER micro-rotation
// registers, one finishing/output register (stage F). Latency ITER+2.
//
// Ports
//   clk        clock (single domain)
//   rst        synchronous, active-high reset
//   in_valid   input sample valid
//   in_ready   engine accepts the sample this cycle
//   gx, gy     signed gradients, IN_W bits
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   mag        unsigned magnitude, rounded, saturated to 2^IN_W-1
//   angle      atan2(gy,gx) in [0,360), units of 2^-ANG_FRAC degrees
//   sector     0 = 0 deg, 1 = 45 deg, 2 = 90 deg, 3 = 135 deg
//
// Handshake: a sample is accepted on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready. The only
// stall source is an unconsumed result (out_valid && !out_ready); while it is
// present every register, valid bits included, holds and in_ready is low.
// out_ready is ignored while out_valid is low, so bubbles never stall.
module cordic_vec_pipe #(
  parameter int IN_W     = 11,
  parameter int ITER     = 12,
  parameter int ANG_FRAC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   gx,
  input  logic signed [IN_W-1:0]   gy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN_W-1:0]          mag,
  output logic [8+ANG_FRAC:0]      angle,
  output logic [1:0]               sector
);

  localparam int W     = IN_W + 2;
  localparam int ANG_W = 9 + ANG_FRAC;
  localparam int PW    = W + 18;

  // Angles are degrees scaled by 2^16.
  localparam logic signed [31:0] Z180 = 32'sd11796480;
  localparam logic signed [31:0] Z360 = 32'sd23592960;
  localparam logic signed [31:0] T22  = 32'sd1474560;   // 22.5
  localparam logic signed [31:0] T67  = 32'sd4423680;   // 67.5
  localparam logic signed [31:0] T112 = 32'sd7372800;   // 112.5
  localparam logic signed [31:0] T157 = 32'sd10321920;  // 157.5

  // 1/K for the CORDIC gain, 0.60725 in Q16.
  localparam logic signed [PW-1:0] MAG_K   = PW'(39797);
  localparam logic signed [PW-1:0] ROUND   = PW'(32768);
  localparam logic signed [PW-1:0] MAG_MAX = PW'((1 << IN_W) - 1);

  function automatic logic signed [31:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = 32'sd2949120;
      1:       atan_lut = 32'sd1740967;
      2:       atan_lut = 32'sd919879;
      3:       atan_lut = 32'sd466945;
      4:       atan_lut = 32'sd234379;
      5:       atan_lut = 32'sd117304;
      6:       atan_lut = 32'sd58666;
      7:       atan_lut = 32'sd29335;
      8:       atan_lut = 32'sd14668;
      9:       atan_lut = 32'sd7334;
      10:      atan_lut = 32'sd3667;
      11:      atan_lut = 32'sd1833;
      12:      atan_lut = 32'sd917;
      13:      atan_lut = 32'sd458;
      14:      atan_lut = 32'sd229;
      15:      atan_lut = 32'sd115;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  // Index k holds the value entering micro-rotation k; index ITER feeds stage F.
  // y after the last rotation is never needed, so y stops at ITER-1.
  logic signed [W-1:0] x_q  [0:ITER];
  logic signed [W-1:0] x_d  [0:ITER];
  logic signed [W-1:0] y_q  [0:ITER-1];
  logic signed [W-1:0] y_d  [0:ITER-1];
  logic signed [31:0]  z_q  [0:ITER];
  logic signed [31:0]  z_d  [0:ITER];
  logic                v_q  [0:ITER];
  logic                v_d  [0:ITER];
  logic                zf_q [0:ITER];
  logic                zf_d [0:ITER];

  logic                out_valid_q, out_valid_d;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic [ANG_W-1:0]    angle_q, angle_d;
  logic [1:0]          sector_q, sector_d;

  logic                stall;
  logic signed [W-1:0] gx_ext, gy_ext;
  logic signed [PW-1:0] x_ext, prod, mag_wide;
  logic signed [31:0]  z_wrap, z_half;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Pre-rotation and micro-rotations.
  always_comb begin
    gx_ext = {{2{gx[IN_W-1]}}, gx};
    gy_ext = {{2{gy[IN_W-1]}}, gy};

    // Left half-plane is folded into the right half by a 180 degree turn.
    if (gx_ext < 0) begin
      x_d[0] = -gx_ext;
      y_d[0] = -gy_ext;
      z_d[0] = Z180;
    end else begin
      x_d[0] = gx_ext;
      y_d[0] = gy_ext;
      z_d[0] = '0;
    end
    v_d[0]  = in_valid;
    zf_d[0] = (gx == '0) && (gy == '0);

    for (int i = 0; i < ITER; i++) begin
      if (!y_q[i][W-1]) begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        z_d[i+1] = z_q[i] + atan_lut(i);
      end else begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        z_d[i+1] = z_q[i] - atan_lut(i);
      end
      v_d[i+1]  = v_q[i];
      zf_d[i+1] = zf_q[i];
    end

    for (int i = 0; i < ITER - 1; i++) begin
      if (!y_q[i][W-1]) y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      else              y_d[i+1] = y_q[i] + (x_q[i] >>> i);
    end
  end

  // Finishing stage: gain compensation, angle wrap, sector classification.
  always_comb begin
    x_ext    = {{18{x_q[ITER][W-1]}}, x_q[ITER]};
    prod     = x_ext * MAG_K;
    mag_wide = (prod + ROUND) >>> 16;

    if (z_q[ITER] < 0) z_wrap = z_q[ITER] + Z360;
    else               z_wrap = z_q[ITER];

    // Direction is an undirected line, so fold onto [0,180).
    if (z_wrap >= Z180) z_half = z_wrap - Z180;
    else                z_half = z_wrap;

    out_valid_d = v_q[ITER];
    mag_d       = '0;
    angle_d     = '0;
    sector_d    = 2'd0;

    if (!zf_q[ITER]) begin
      if (mag_wide < 0)             mag_d = '0;
      else if (mag_wide > MAG_MAX)  mag_d = {IN_W{1'b1}};
      else                          mag_d = IN_W'(mag_wide);

      angle_d = ANG_W'(z_wrap >>> (16 - ANG_FRAC));

      if (z_half < T22 || z_half >= T157) sector_d = 2'd0;
      else if (z_half < T67)              sector_d = 2'd1;
      else if (z_half < T112)             sector_d = 2'd2;
      else                                sector_d = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i]  <= '0;
        z_q[i]  <= '0;
        v_q[i]  <= 1'b0;
        zf_q[i] <= 1'b0;
      end
      for (int i = 0; i < ITER; i++) y_q[i] <= '0;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      angle_q     <= '0;
      sector_q    <= 2'd0;
    end else if (!stall) begin
      for (int i = 0; i <= ITER; i++) begin
        x_q[i]  <= x_d[i];
        z_q[i]  <= z_d[i];
        v_q[i]  <= v_d[i];
        zf_q[i] <= zf_d[i];
      end
      for (int i = 0; i < ITER; i++) y_q[i] <= y_d[i];
      out_valid_q <= out_valid_d;
      mag_q       <= mag_d;
      angle_q     <= angle_d;
      sector_q    <= sector_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mag       = mag_q;
  assign angle     = angle_q;
  assign sector    = sector_q;

endmodule

// File: tb/tb_cordic_vec_pipe.sv
module tb_cordic_vec_pipe;

  localparam int IN_W     = 11;
  localparam int ITER     = 12;
  localparam int ANG_FRAC = 4;
  localparam int ANG_W    = 9 + ANG_FRAC;
  localparam int RES_W    = 2 + ANG_W + IN_W;
  localparam real PI      = 3.14159265358979323846;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] gx;
  logic signed [IN_W-1:0] gy;
  logic                   out_valid;
  logic                   out_ready;
  logic [IN_W-1:0]        mag;
  logic [ANG_W-1:0]       angle;
  logic [1:0]             sector;

  cordic_vec_pipe #(.IN_W(IN_W), .ITER(ITER), .ANG_FRAC(ANG_FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gx        (gx),
    .gy        (gy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .angle     (angle),
    .sector    (sector)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  bit lat_check = 1'b1;

  logic [RES_W-1:0] exp_q[$];
  int               acc_q[$];
  int               atan_fx[16];

  logic [IN_W-1:0]  last_mag;
  logic [ANG_W-1:0] last_angle;
  logic [1:0]       last_sector;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input real obs, input real exp, input real tol);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f tol=%f", tag, obs, exp, tol);
    end
  endtask

  // Reference: the vectoring recurrence run as a plain loop on integers,
  // with the table derived from $atan and the sector from degrees.
  function automatic logic [RES_W-1:0] model(input int vx, input int vy);
    int     x, y, z, dx, dy, ang;
    longint m;
    real    deg;
    logic [1:0] sec;
    if (vx == 0 && vy == 0) return '0;
    if (vx < 0) begin x = -vx; y = -vy; z = 180 * 65536; end
    else        begin x = vx;  y = vy;  z = 0;           end
    for (int i = 0; i < ITER; i++) begin
      dx = y >>> i;
      dy = x >>> i;
      if (y >= 0) begin x = x + dx; y = y - dy; z = z + atan_fx[i]; end
      else        begin x = x - dx; y = y + dy; z = z - atan_fx[i]; end
    end
    m = (longint'(x) * 39797 + 32768) >>> 16;
    if (m > (1 << IN_W) - 1) m = (1 << IN_W) - 1;
    if (m < 0) m = 0;
    if (z < 0) z = z + 360 * 65536;
    ang = z >>> (16 - ANG_FRAC);
    deg = real'(z) / 65536.0;
    if (deg >= 180.0) deg = deg - 180.0;
    if (deg < 22.5 || deg >= 157.5) sec = 2'd0;
    else if (deg < 67.5)            sec = 2'd1;
    else if (deg < 112.5)           sec = 2'd2;
    else                            sec = 2'd3;
    return {sec, ang[ANG_W-1:0], m[IN_W-1:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  bit               hold_prev = 1'b0;
  logic [IN_W-1:0]  prev_mag;
  logic [ANG_W-1:0] prev_angle;
  logic [1:0]       prev_sector;

  always @(negedge clk) begin
    logic [RES_W-1:0] e;
    int a;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (hold_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_mag", mag, prev_mag);
        check("stall_angle", angle, prev_angle);
        check("stall_sector", sector, prev_sector);
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_output observed=mag %0d expected=no result", mag);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("mag", mag, e[IN_W-1:0]);
          check("angle", angle, e[IN_W+ANG_W-1:IN_W]);
          check("sector", sector, e[RES_W-1:RES_W-2]);
          if (lat_check) check("latency", cyc - a, ITER + 2);
          pops++;
          last_mag    = mag;
          last_angle  = angle;
          last_sector = sector;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(gx), int'(gy)));
        acc_q.push_back(cyc);
        pushes++;
      end
      hold_prev   = out_valid && !out_ready;
      prev_mag    = mag;
      prev_angle  = angle;
      prev_sector = sector;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec();
    gx = IN_W'($urandom_range(0, (1 << IN_W) - 1));
    gy = IN_W'($urandom_range(0, (1 << IN_W) - 1));
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input int vx, input int vy, input bit chk_ang);
    real im, ia, oa, d;
    gx = IN_W'(vx);
    gy = IN_W'(vy);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain(tag, 4 * ITER);
    im = $sqrt(real'(vx) * vx + real'(vy) * vy);
    check_tol({tag, "_ideal_mag"}, real'(last_mag), im, real'(ITER));
    if (chk_ang) begin
      ia = $atan2(real'(vy), real'(vx)) * 180.0 / PI;
      if (ia < 0.0) ia = ia + 360.0;
      oa = real'(last_angle) / real'(1 << ANG_FRAC);
      d  = oa - ia;
      if (d > 180.0)  d = d - 360.0;
      if (d < -180.0) d = d + 360.0;
      check_tol({tag, "_ideal_angle"}, d, 0.0, 1.0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++)
      atan_fx[i] = $rtoi($atan(1.0 / real'(1 << i)) * 180.0 / PI * 65536.0 + 0.5);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gx = '0; gy = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mag", mag, 0);
    check("rst_angle", angle, 0);
    check("rst_sector", sector, 0);
    check("rst_in_ready", in_ready, 1'b1);

    // Axis, diagonal, quadrant and extreme vectors
    directed("v100_0", 100, 0, 1'b1);
    check("v100_0_sector", last_sector, 0);
    directed("v0_100", 0, 100, 1'b1);
    check("v0_100_sector", last_sector, 2);
    directed("vm100_0", -100, 0, 1'b1);
    check("vm100_0_sector", last_sector, 0);
    directed("vm100_m100", -100, -100, 1'b1);
    check("vm100_m100_sector", last_sector, 1);
    directed("v3_m4", 3, -4, 1'b0);
    check("v3_m4_sector", last_sector, 3);
    directed("v0_0", 0, 0, 1'b0);
    check("v0_0_mag", last_mag, 0);
    check("v0_0_angle", last_angle, 0);
    check("v0_0_sector", last_sector, 0);
    directed("vm1024_m1024", -1024, -1024, 1'b1);
    directed("vm1024_0", -1024, 0, 1'b1);
    directed("v0_m1024", 0, -1024, 1'b1);

    // Streaming: one input per cycle, out_ready held high
    for (int n = 0; n < 1000; n++) begin
      in_valid = 1'b1;
      rand_vec();
      step();
    end
    in_valid = 1'b0;
    drain("stream_drain", 4 * ITER);
    check("stream_count", pops, pushes);

    // Backpressure: random valid/ready
    lat_check = 1'b0;
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rand_vec();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("bp_drain", 8 * ITER);
    check("bp_count", pops, pushes);
    lat_check = 1'b1;

    // Reset with five samples in flight
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      rand_vec();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    pops = 0;
    pushes = 0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_mag", mag, 0);
    check("midrst_angle", angle, 0);
    check("midrst_sector", sector, 0);
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < ITER + 6; k++) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      step();
      check("midrst_no_stale", stale, 0);
    end
    directed("fresh_after_rst", 300, 200, 1'b1);
    check("fresh_count", pops, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
